// File: rtl/switch_debouncer.sv
// Synchronises a bouncing switch input and qualifies each level change over
// STABLE_CYCLES samples, producing a clean level plus rise/fall strobes.
module switch_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("switch_debouncer: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("switch_debouncer: SYNC_STAGES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_d, rise_d, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            dout    <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout    <= dout_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Any sample back at the settled level drops the candidate entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        dout_d  = dout;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CMAX) begin
                    state_d = IDLE_HIGH;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CMAX) begin
                    state_d = IDLE_LOW;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
    end

    assign busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule
